// File: rtl/snoop_controller.sv
// Bus-side MSI snoop controller: direct-mapped tag/state table, snoop
// downgrade/invalidate, write-back/abort handshake and local table writes.
module snoop_controller #(
    parameter int ADDR_W = 8,
    parameter int IDX_W  = 2
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      bus_valid,
    output logic                      bus_ready,
    input  logic [1:0]                bus_msg,
    input  logic [ADDR_W-1:0]         bus_addr,
    input  logic                      loc_we,
    input  logic [IDX_W-1:0]          loc_index,
    input  logic [ADDR_W-IDX_W-1:0]   loc_tag,
    input  logic [1:0]                loc_state,
    output logic                      loc_conflict,
    input  logic [IDX_W-1:0]          rd_index,
    output logic [ADDR_W-IDX_W-1:0]   rd_tag,
    output logic [1:0]                rd_state,
    output logic                      snoop_hit,
    output logic                      abort_mem,
    output logic                      wb_req,
    output logic [ADDR_W-1:0]         wb_addr,
    input  logic                      wb_ack,
    output logic                      proto_err
);
    localparam int TAG_W     = ADDR_W - IDX_W;
    localparam int NUM_LINES = 2 ** IDX_W;

    localparam logic [1:0] MSG_NONE = 2'b00;
    localparam logic [1:0] MSG_RD   = 2'b01;
    localparam logic [1:0] MSG_INV  = 2'b10;
    localparam logic [1:0] MSG_WR   = 2'b11;

    typedef enum logic [1:0] {LINE_I = 2'b00, LINE_E = 2'b01, LINE_S = 2'b10} line_t;
    typedef enum logic {IDLE, WB} state_t;

    logic [TAG_W-1:0]  tag_q [NUM_LINES];
    line_t             st_q  [NUM_LINES];
    state_t            state_q, state_d;
    logic [ADDR_W-1:0] wb_addr_q;
    logic              pend_rd_q;
    logic              snoop_hit_p1, abort_p1, conflict_p1, proto_err_q;

    logic [IDX_W-1:0]  s_idx, wb_idx;
    logic [TAG_W-1:0]  s_tag;
    logic              accept, snoop, hit, hit_e, go_wb, ack, loc_block;
    line_t             loc_st;

    assign s_idx  = bus_addr[IDX_W-1:0];
    assign s_tag  = bus_addr[ADDR_W-1:IDX_W];
    assign wb_idx = wb_addr_q[IDX_W-1:0];

    // A no-op message is accepted but never counts as a snoop of a line.
    assign accept = bus_valid && bus_ready;
    assign snoop  = accept && (bus_msg != MSG_NONE);
    assign hit    = snoop && (st_q[s_idx] != LINE_I) && (tag_q[s_idx] == s_tag);
    assign hit_e  = hit && (st_q[s_idx] == LINE_E);
    assign go_wb  = hit_e && ((bus_msg == MSG_RD) || (bus_msg == MSG_WR));
    assign ack    = (state_q == WB) && wb_ack;

    // Snoop traffic owns its index this edge, and the pending WB line is
    // owned by the write-back until it completes.
    assign loc_block = (snoop && (loc_index == s_idx)) ||
                       ((state_q == WB) && (loc_index == wb_idx));
    assign loc_st    = (loc_state == 2'b01) ? LINE_E :
                       (loc_state == 2'b10) ? LINE_S : LINE_I;

    assign bus_ready    = (state_q == IDLE);
    assign wb_req       = (state_q == WB);
    assign wb_addr      = wb_addr_q;
    assign snoop_hit    = snoop_hit_p1;
    assign abort_mem    = abort_p1;
    assign loc_conflict = conflict_p1;
    assign proto_err    = proto_err_q;
    assign rd_tag       = tag_q[rd_index];
    assign rd_state     = st_q[rd_index];

    // Table update: local write, snoop downgrade/invalidate, WB completion.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NUM_LINES; i++) begin
                tag_q[i] <= '0;
                st_q[i]  <= LINE_I;
            end
        end else begin
            if (loc_we && !loc_block) begin
                tag_q[loc_index] <= loc_tag;
                st_q[loc_index]  <= loc_st;
            end
            if (hit && (bus_msg != MSG_RD) && !go_wb) begin
                st_q[s_idx] <= LINE_I;
            end
            if (ack) begin
                st_q[wb_idx] <= pend_rd_q ? LINE_S : LINE_I;
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clock) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // FSM next state: an Exclusive hit on a miss parks in WB until acked.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (go_wb) state_d = WB;
            WB:      if (ack)   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Registered pulses, sticky error and write-back bookkeeping.
    always_ff @(posedge clock) begin
        if (reset) begin
            snoop_hit_p1 <= 1'b0;
            abort_p1     <= 1'b0;
            conflict_p1  <= 1'b0;
            proto_err_q  <= 1'b0;
            wb_addr_q    <= '0;
            pend_rd_q    <= 1'b0;
        end else begin
            snoop_hit_p1 <= hit;
            abort_p1     <= go_wb;
            conflict_p1  <= loc_we && loc_block;
            proto_err_q  <= proto_err_q || (hit_e && (bus_msg == MSG_INV));
            if (go_wb) begin
                wb_addr_q <= bus_addr;
                pend_rd_q <= (bus_msg == MSG_RD);
            end
        end
    end
endmodule

// File: tb/tb_snoop_controller.sv
// Testbench for snoop_controller: directed vector table plus randomized
// traffic checked against a behavioural line-table model.
module tb_snoop_controller;
    logic       clock = 1'b0;
    logic       reset, bus_valid, bus_ready;
    logic [1:0] bus_msg;
    logic [7:0] bus_addr;
    logic       loc_we, loc_conflict;
    logic [1:0] loc_index, loc_state;
    logic [5:0] loc_tag;
    logic [1:0] rd_index, rd_state;
    logic [5:0] rd_tag;
    logic       snoop_hit, abort_mem, wb_req, wb_ack, proto_err;
    logic [7:0] wb_addr;

    always #5 clock = ~clock;

    snoop_controller #(.ADDR_W(8), .IDX_W(2)) dut (
        .clock(clock), .reset(reset), .bus_valid(bus_valid), .bus_ready(bus_ready),
        .bus_msg(bus_msg), .bus_addr(bus_addr), .loc_we(loc_we), .loc_index(loc_index),
        .loc_tag(loc_tag), .loc_state(loc_state), .loc_conflict(loc_conflict),
        .rd_index(rd_index), .rd_tag(rd_tag), .rd_state(rd_state),
        .snoop_hit(snoop_hit), .abort_mem(abort_mem), .wb_req(wb_req),
        .wb_addr(wb_addr), .wb_ack(wb_ack), .proto_err(proto_err)
    );

    typedef struct {
        logic       rst, bv;
        logic [1:0] msg;
        logic [7:0] addr;
        logic       we;
        logic [1:0] li;
        logic [5:0] lt;
        logic [1:0] ls;
        logic       ack;
        logic       er, ew;
        logic [7:0] ewa;
        logic       eh, ea, ec, ep;
        logic [1:0] ei, es;
    } vec_t;

    vec_t tbl[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Behavioural model: line table plus write-back bookkeeping.
    logic [5:0] m_tag [4];
    logic [1:0] m_st  [4];
    bit         m_busy, m_pend_rd, m_hit, m_abort, m_conf, m_perr;
    logic [7:0] m_wba;

    function automatic vec_t mk(logic rst, logic bv, logic [1:0] msg, logic [7:0] addr,
                                logic we, logic [1:0] li, logic [5:0] lt, logic [1:0] ls,
                                logic ack, logic er, logic ew, logic [7:0] ewa, logic eh,
                                logic ea, logic ec, logic ep, logic [1:0] ei, logic [1:0] es);
        vec_t v;
        v.rst = rst; v.bv = bv; v.msg = msg; v.addr = addr; v.we = we; v.li = li;
        v.lt = lt; v.ls = ls; v.ack = ack; v.er = er; v.ew = ew; v.ewa = ewa;
        v.eh = eh; v.ea = ea; v.ec = ec; v.ep = ep; v.ei = ei; v.es = es;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input vec_t x);
        reset     = x.rst;
        bus_valid = x.bv;
        bus_msg   = x.msg;
        bus_addr  = x.addr;
        loc_we    = x.we;
        loc_index = x.li;
        loc_tag   = x.lt;
        loc_state = x.ls;
        wb_ack    = x.ack;
    endtask

    // Advance the model across one rising edge given the inputs held before it.
    task automatic model_clock(input vec_t x);
        int si, wi;
        bit snp, hit, blocked;
        if (x.rst) begin
            for (int i = 0; i < 4; i++) begin m_tag[i] = '0; m_st[i] = 2'd0; end
            m_busy = 0; m_pend_rd = 0; m_hit = 0; m_abort = 0; m_conf = 0; m_perr = 0;
            m_wba = '0;
            return;
        end
        si      = int'(x.addr[1:0]);
        wi      = int'(m_wba[1:0]);
        snp     = x.bv && !m_busy && (x.msg != 2'd0);
        hit     = snp && (m_st[si] != 2'd0) && (m_tag[si] == x.addr[7:2]);
        blocked = (snp && int'(x.li) == si) || (m_busy && int'(x.li) == wi);
        m_conf  = x.we && blocked;
        m_hit   = hit;
        m_abort = 0;
        if (x.we && !blocked) begin
            m_tag[x.li] = x.lt;
            m_st[x.li]  = (x.ls == 2'd3) ? 2'd0 : x.ls;
        end
        if (m_busy) begin
            if (x.ack) begin
                m_st[wi] = m_pend_rd ? 2'd2 : 2'd0;
                m_busy   = 0;
            end
        end else if (hit) begin
            if (m_st[si] == 2'd1) begin
                if (x.msg == 2'd2) begin
                    m_st[si] = 2'd0;
                    m_perr   = 1;
                end else begin
                    m_busy    = 1;
                    m_abort   = 1;
                    m_wba     = x.addr;
                    m_pend_rd = (x.msg == 2'd1);
                end
            end else if (x.msg != 2'd1) begin
                m_st[si] = 2'd0;
            end
        end
    endtask

    initial begin
        vec_t x;
        drive(mk(1,0,0,0, 0,0,0,0,0, 0,0,0,0,0,0,0, 0,0));
        rd_index = 2'd0;

        //  rst bv msg addr   we li lt    ls ack  er ew ewa   eh ea ec ep  ei es
        tbl.push_back(mk(1,0,0,8'h00, 0,0,6'h00,0,0, 1,0,8'h00,0,0,0,0, 0,0));
        tbl.push_back(mk(0,0,0,8'h00, 1,1,6'h0D,2,0, 1,0,8'h00,0,0,0,0, 1,2));
        tbl.push_back(mk(0,1,1,8'h35, 0,0,6'h00,0,0, 1,0,8'h00,1,0,0,0, 1,2));
        tbl.push_back(mk(0,1,3,8'h35, 0,0,6'h00,0,0, 1,0,8'h00,1,0,0,0, 1,0));
        tbl.push_back(mk(0,0,0,8'h00, 1,2,6'h3F,1,0, 1,0,8'h00,0,0,0,0, 2,1));
        tbl.push_back(mk(0,1,1,8'hFE, 0,0,6'h00,0,0, 0,1,8'hFE,1,1,0,0, 2,1));
        tbl.push_back(mk(0,0,0,8'h00, 1,2,6'h00,0,0, 0,1,8'hFE,0,0,1,0, 2,1));
        tbl.push_back(mk(0,0,0,8'h00, 1,0,6'h05,2,0, 0,1,8'hFE,0,0,0,0, 0,2));
        tbl.push_back(mk(0,0,0,8'h00, 0,0,6'h00,0,1, 1,0,8'h00,0,0,0,0, 2,2));
        tbl.push_back(mk(0,0,0,8'h00, 1,3,6'h10,1,0, 1,0,8'h00,0,0,0,0, 3,1));
        tbl.push_back(mk(0,1,3,8'h43, 0,0,6'h00,0,0, 0,1,8'h43,1,1,0,0, 3,1));
        tbl.push_back(mk(0,1,1,8'hFE, 0,0,6'h00,0,1, 1,0,8'h00,0,0,0,0, 3,0));
        tbl.push_back(mk(0,1,1,8'hFE, 0,0,6'h00,0,0, 1,0,8'h00,1,0,0,0, 2,2));
        tbl.push_back(mk(0,0,0,8'h00, 1,1,6'h0D,1,0, 1,0,8'h00,0,0,0,0, 1,1));
        tbl.push_back(mk(0,1,1,8'h31, 0,0,6'h00,0,0, 1,0,8'h00,0,0,0,0, 1,1));
        tbl.push_back(mk(0,0,0,8'h00, 1,1,6'h0D,2,0, 1,0,8'h00,0,0,0,0, 1,2));
        tbl.push_back(mk(0,1,2,8'h35, 1,1,6'h01,1,0, 1,0,8'h00,1,0,1,0, 1,0));
        tbl.push_back(mk(0,0,0,8'h00, 1,0,6'h05,1,0, 1,0,8'h00,0,0,0,0, 0,1));
        tbl.push_back(mk(0,1,2,8'h14, 0,0,6'h00,0,0, 1,0,8'h00,1,0,0,1, 0,0));
        tbl.push_back(mk(0,0,0,8'h00, 0,0,6'h00,0,0, 1,0,8'h00,0,0,0,1, 0,0));
        tbl.push_back(mk(0,0,0,8'h00, 1,0,6'h05,1,0, 1,0,8'h00,0,0,0,1, 0,1));
        tbl.push_back(mk(0,1,1,8'h14, 0,0,6'h00,0,0, 0,1,8'h14,1,1,0,1, 0,1));
        tbl.push_back(mk(1,0,0,8'h00, 0,0,6'h00,0,0, 1,0,8'h00,0,0,0,0, 0,0));

        foreach (tbl[k]) begin
            drive(tbl[k]);
            rd_index = tbl[k].ei;
            @(posedge clock); #1;
            chk($sformatf("v%0d bus_ready", k), 32'(bus_ready), 32'(tbl[k].er));
            chk($sformatf("v%0d wb_req", k), 32'(wb_req), 32'(tbl[k].ew));
            if (tbl[k].ew || tbl[k].rst)
                chk($sformatf("v%0d wb_addr", k), 32'(wb_addr), 32'(tbl[k].ewa));
            chk($sformatf("v%0d snoop_hit", k), 32'(snoop_hit), 32'(tbl[k].eh));
            chk($sformatf("v%0d abort_mem", k), 32'(abort_mem), 32'(tbl[k].ea));
            chk($sformatf("v%0d loc_conflict", k), 32'(loc_conflict), 32'(tbl[k].ec));
            chk($sformatf("v%0d proto_err", k), 32'(proto_err), 32'(tbl[k].ep));
            chk($sformatf("v%0d rd_state", k), 32'(rd_state), 32'(tbl[k].es));
        end

        // Reset taken during WB must leave every line Invalid with tag 0.
        for (int i = 0; i < 4; i++) begin
            rd_index = 2'(i);
            #1;
            chk($sformatf("post-reset state[%0d]", i), 32'(rd_state), 32'd0);
            chk($sformatf("post-reset tag[%0d]", i), 32'(rd_tag), 32'd0);
        end

        // Randomized traffic against the model; small tag space to force hits.
        for (int c = 0; c < 4000; c++) begin
            x.rst  = (c == 0) || ($urandom_range(0, 299) == 0);
            x.bv   = ($urandom_range(0, 2) != 0);
            x.msg  = 2'($urandom_range(0, 3));
            x.addr = {6'($urandom_range(0, 2)), 2'($urandom_range(0, 3))};
            x.we   = ($urandom_range(0, 3) == 0);
            x.li   = 2'($urandom_range(0, 3));
            x.lt   = 6'($urandom_range(0, 2));
            x.ls   = 2'($urandom_range(0, 3));
            x.ack  = ($urandom_range(0, 2) == 0);
            drive(x);
            rd_index = 2'($urandom_range(0, 3));
            model_clock(x);
            @(posedge clock); #1;
            chk($sformatf("r%0d bus_ready", c), 32'(bus_ready), 32'(!m_busy));
            chk($sformatf("r%0d wb_req", c), 32'(wb_req), 32'(m_busy));
            if (m_busy)
                chk($sformatf("r%0d wb_addr", c), 32'(wb_addr), 32'(m_wba));
            chk($sformatf("r%0d snoop_hit", c), 32'(snoop_hit), 32'(m_hit));
            chk($sformatf("r%0d abort_mem", c), 32'(abort_mem), 32'(m_abort));
            chk($sformatf("r%0d loc_conflict", c), 32'(loc_conflict), 32'(m_conf));
            chk($sformatf("r%0d proto_err", c), 32'(proto_err), 32'(m_perr));
            chk($sformatf("r%0d rd_state", c), 32'(rd_state), 32'(m_st[rd_index]));
            chk($sformatf("r%0d rd_tag", c), 32'(rd_tag), 32'(m_tag[rd_index]));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
